// File: rtl/ddr_pkg.sv
// Shared types and mode-register layout for the DDR4 init sequencer.
// MR programming order, field offsets and the opcode builder live here.
package ddr_pkg;

  typedef enum logic [3:0] {
    ST_CKE_WAIT,
    ST_IS_WAIT,
    ST_XPR,
    ST_MRS,
    ST_MRD,
    ST_MOD,
    ST_ZQCL,
    ST_ZQW,
    ST_DONE
  } init_state_e;

  localparam logic [2:0] MR0 = 3'd0;
  localparam logic [2:0] MR1 = 3'd1;
  localparam logic [2:0] MR2 = 3'd2;
  localparam logic [2:0] MR3 = 3'd3;
  localparam logic [2:0] MR4 = 3'd4;
  localparam logic [2:0] MR5 = 3'd5;
  localparam logic [2:0] MR6 = 3'd6;

  localparam int NUM_MRS = 7;
  localparam logic [2:0] MR_ORDER [NUM_MRS] = '{MR3, MR6, MR5, MR4, MR2, MR1, MR0};

  localparam int ADDR_W         = 17;
  localparam int MODE_W         = 20;
  localparam int MR_IDX_LSB     = 17;
  localparam int MR6_TCCD_LSB   = 10;
  localparam int MR4_WR_PRE_BIT = 12;
  localparam int MR4_RD_PRE_BIT = 11;
  localparam int MR2_CWL_LSB    = 3;
  localparam int MR1_AL_LSB     = 3;
  localparam int MR0_BL_LSB     = 0;

  typedef struct packed {
    logic [2:0] tccd;
    logic       wr_pre;
    logic       rd_pre;
    logic [2:0] cwl;
    logic [1:0] al;
    logic [3:0] cl;
    logic [1:0] bl;
  } init_cfg_t;

  // MR3/MR5 and every bit not named below stay zero.
  function automatic logic [ADDR_W-1:0] mr_opcode(input logic [2:0] mr, input init_cfg_t cfg);
    logic [ADDR_W-1:0] a;
    a = '0;
    case (mr)
      MR6: a[MR6_TCCD_LSB +: 3] = cfg.tccd;
      MR4: begin
        a[MR4_WR_PRE_BIT] = cfg.wr_pre;
        a[MR4_RD_PRE_BIT] = cfg.rd_pre;
      end
      MR2: a[MR2_CWL_LSB +: 3] = cfg.cwl;
      MR1: a[MR1_AL_LSB +: 2] = cfg.al;
      MR0: begin
        // CAS latency is scattered over A6,A5,A4,A2
        a[6] = cfg.cl[3];
        a[5] = cfg.cl[2];
        a[4] = cfg.cl[1];
        a[2] = cfg.cl[0];
        a[MR0_BL_LSB +: 2] = cfg.bl;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ddr_init_timer.sv
// Loadable down-counter used for every wait phase of the init sequence.
// Holds at zero rather than wrapping; zero flag drives the FSM.
module ddr_init_timer #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ddr_init_seq.sv
// Multi-rank DDR4 power-up/re-init sequencer: CKE, MR3..MR0 per rank, optional ZQCL.
// Define DDR_INIT_ZQCL_EN to include the per-rank ZQCL/ZQW phases.
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int NUM_RANKS = 1,
  parameter int CNT_W     = 16,
  parameter int T_CKE     = 10,
  parameter int T_IS      = 2,
  parameter int T_XPR     = 5,
  parameter int T_MRD     = 8,
  parameter int T_MOD     = 24,
  parameter int T_ZQ      = 512
) (
  input  logic                 CK_t,
  input  logic                 reset,
  input  logic                 init_req,
  input  logic [2:0]           cfg_tCCD,
  input  logic                 cfg_WR_PRE,
  input  logic                 cfg_RD_PRE,
  input  logic [2:0]           cfg_CWL,
  input  logic [1:0]           cfg_AL,
  input  logic [3:0]           cfg_CL,
  input  logic [1:0]           cfg_BL,
  output logic                 CKE,
  output logic [NUM_RANKS-1:0] cs_n,
  output logic                 des_rdy,
  output logic                 mrs_rdy,
  output logic                 zqcl_rdy,
  output logic [MODE_W-1:0]    mode_reg,
  output logic                 ini_done
);

  localparam int RANK_W = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  localparam logic [CNT_W-1:0] LD_CKE = CNT_W'(T_CKE - T_IS - 1);
  localparam logic [CNT_W-1:0] LD_IS  = CNT_W'(T_IS - 1);
  localparam logic [CNT_W-1:0] LD_XPR = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQ  = CNT_W'(T_ZQ - 1);

  if (T_CKE <= T_IS) begin : g_bad_cke
    $error("ddr_init_seq: T_CKE must be greater than T_IS");
  end
  if (T_IS < 1 || T_XPR < 1 || T_MRD < 1 || T_MOD < 1 || T_ZQ < 1) begin : g_bad_t
    $error("ddr_init_seq: every T_* parameter must be >= 1");
  end
  if (T_ZQ > (2 ** CNT_W) || T_CKE > (2 ** CNT_W) || T_MOD > (2 ** CNT_W)) begin : g_bad_w
    $error("ddr_init_seq: CNT_W too narrow for the timing parameters");
  end
  if (NUM_RANKS < 1) begin : g_bad_r
    $error("ddr_init_seq: NUM_RANKS must be >= 1");
  end

  init_state_e            r_state;
  init_state_e            w_next;
  logic [RANK_W-1:0]      r_rank;
  logic [2:0]             r_mr_pos;
  logic                   r_cfg_pend;
  init_cfg_t              r_cfg;
  init_cfg_t              w_cfg_in;
  logic                   w_zero;
  logic                   w_load;
  logic [CNT_W-1:0]       w_load_val;
  logic                   w_last_mr;
  logic                   w_last_rank;
  logic [2:0]             w_mr_idx;
  logic [NUM_RANKS-1:0]   w_rank_onehot;

  assign w_cfg_in      = {cfg_tCCD, cfg_WR_PRE, cfg_RD_PRE, cfg_CWL, cfg_AL, cfg_CL, cfg_BL};
  assign w_last_mr     = (r_mr_pos == 3'(NUM_MRS - 1));
  assign w_last_rank   = (r_rank == RANK_W'(NUM_RANKS - 1));
  assign w_mr_idx      = MR_ORDER[r_mr_pos];
  assign w_rank_onehot = NUM_RANKS'(1) << r_rank;

  // Reset value lets CKE_WAIT count immediately after reset release.
  ddr_init_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_CKE)
  ) u_timer (
    .i_clk      (CK_t),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_state <= ST_CKE_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CKE_WAIT: if (w_zero) w_next = ST_IS_WAIT;
      ST_IS_WAIT:  if (w_zero) w_next = ST_XPR;
      ST_XPR:      if (w_zero) w_next = ST_MRS;
      ST_MRS:      w_next = (w_last_mr && w_last_rank) ? ST_MOD : ST_MRD;
      ST_MRD:      if (w_zero) w_next = ST_MRS;
`ifdef DDR_INIT_ZQCL_EN
      ST_MOD:      if (w_zero) w_next = ST_ZQCL;
      ST_ZQCL:     w_next = ST_ZQW;
      ST_ZQW:      if (w_zero) w_next = w_last_rank ? ST_DONE : ST_ZQCL;
`else
      ST_MOD:      if (w_zero) w_next = ST_DONE;
`endif
      ST_DONE:     if (init_req) w_next = ST_CKE_WAIT;
      default:     w_next = ST_CKE_WAIT;
    endcase
  end

  // Timer reloads on every state change with the duration of the state being entered.
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = '0;
    case (w_next)
      ST_CKE_WAIT: w_load_val = LD_CKE;
      ST_IS_WAIT:  w_load_val = LD_IS;
      ST_XPR:      w_load_val = LD_XPR;
      ST_MRD:      w_load_val = LD_MRD;
      ST_MOD:      w_load_val = LD_MOD;
      ST_ZQW:      w_load_val = LD_ZQ;
      default:     w_load_val = '0;
    endcase
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_rank     <= '0;
      r_mr_pos   <= '0;
      r_cfg_pend <= 1'b1;
    end else begin
      r_cfg_pend <= (r_state == ST_DONE) && init_req;
      case (r_state)
        ST_MRS: begin
          if (w_last_mr) begin
            r_mr_pos <= '0;
            r_rank   <= w_last_rank ? '0 : r_rank + RANK_W'(1);
          end else begin
            r_mr_pos <= r_mr_pos + 3'd1;
          end
        end
        ST_ZQW: if (w_zero && !w_last_rank) r_rank <= r_rank + RANK_W'(1);
        ST_DONE: begin
          if (init_req) begin
            r_rank   <= '0;
            r_mr_pos <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Configuration snapshot on the first CKE_WAIT cycle; pure data, no reset needed.
  always_ff @(posedge CK_t) begin
    if (r_cfg_pend) r_cfg <= w_cfg_in;
  end

  always_comb begin
    CKE      = 1'b1;
    cs_n     = '1;
    des_rdy  = 1'b0;
    mrs_rdy  = 1'b0;
    zqcl_rdy = 1'b0;
    mode_reg = '0;
    ini_done = 1'b0;
    case (r_state)
      ST_CKE_WAIT: CKE = 1'b0;
      ST_XPR, ST_MRD, ST_MOD, ST_ZQW: des_rdy = 1'b1;
      ST_MRS: begin
        mrs_rdy  = 1'b1;
        cs_n     = ~w_rank_onehot;
        mode_reg = {w_mr_idx, mr_opcode(w_mr_idx, r_cfg)};
      end
`ifdef DDR_INIT_ZQCL_EN
      ST_ZQCL: begin
        zqcl_rdy = 1'b1;
        cs_n     = ~w_rank_onehot;
      end
`endif
      ST_DONE: ini_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_init_seq.sv
// Self-checking bench for ddr_init_seq (two ranks) against a cycle-indexed timeline model.
module tb_ddr_init_seq;

  localparam int NR    = 2;
  localparam int T_CKE = 10;
  localparam int T_IS  = 2;
  localparam int T_XPR = 5;
  localparam int T_MRD = 8;
  localparam int T_MOD = 24;
  localparam int T_ZQ  = 512;
`ifdef DDR_INIT_ZQCL_EN
  localparam bit ZQ = 1'b1;
`else
  localparam bit ZQ = 1'b0;
`endif

  typedef struct packed {
    logic          cke;
    logic [NR-1:0] cs_n;
    logic          des;
    logic          mrs;
    logic          zq;
    logic [19:0]   mode;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic [2:0]    tccd;
  logic          wr_pre;
  logic          rd_pre;
  logic [2:0]    cwl;
  logic [1:0]    al;
  logic [3:0]    cl;
  logic [1:0]    bl;
  logic          cke;
  logic [NR-1:0] cs_n;
  logic          des_rdy;
  logic          mrs_rdy;
  logic          zqcl_rdy;
  logic [19:0]   mode_reg;
  logic          ini_done;
  obs_t          obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_init_seq #(
    .NUM_RANKS (NR),
    .CNT_W     (16),
    .T_CKE     (T_CKE),
    .T_IS      (T_IS),
    .T_XPR     (T_XPR),
    .T_MRD     (T_MRD),
    .T_MOD     (T_MOD),
    .T_ZQ      (T_ZQ)
  ) dut (
    .CK_t       (clk),
    .reset      (rst),
    .init_req   (init_req),
    .cfg_tCCD   (tccd),
    .cfg_WR_PRE (wr_pre),
    .cfg_RD_PRE (rd_pre),
    .cfg_CWL    (cwl),
    .cfg_AL     (al),
    .cfg_CL     (cl),
    .cfg_BL     (bl),
    .CKE        (cke),
    .cs_n       (cs_n),
    .des_rdy    (des_rdy),
    .mrs_rdy    (mrs_rdy),
    .zqcl_rdy   (zqcl_rdy),
    .mode_reg   (mode_reg),
    .ini_done   (ini_done)
  );

  assign obs = {cke, cs_n, des_rdy, mrs_rdy, zqcl_rdy, mode_reg, ini_done};

  function automatic int first_mrs();
    return T_CKE + T_XPR;
  endfunction

  function automatic int last_mrs();
    return first_mrs() + (7 * NR - 1) * (T_MRD + 1);
  endfunction

  function automatic int zq_start();
    return last_mrs() + T_MOD + 1;
  endfunction

  function automatic int done_at();
    return zq_start() + (ZQ ? NR * (T_ZQ + 1) : 0);
  endfunction

  // Expected outputs n edges after reset release (or after the honoured init_req edge).
  // c = {tCCD[2:0], WR_PRE, RD_PRE, CWL[2:0], AL[1:0], CL[3:0], BL[1:0]}
  function automatic obs_t model(input int n, input logic [15:0] c);
    obs_t        e;
    int          order [7];
    int          k;
    int          idx;
    int          j;
    logic [16:0] a;
    logic [2:0]  mr;
    order = '{3, 6, 5, 4, 2, 1, 0};
    e = '0;
    e.cs_n = '1;
    e.cke = (n >= T_CKE - T_IS);
    if (n >= done_at()) begin
      e.done = 1'b1;
    end else if (n >= T_CKE && n < first_mrs()) begin
      e.des = 1'b1;
    end else if (n >= first_mrs() && n <= last_mrs()) begin
      k = n - first_mrs();
      if (k % (T_MRD + 1) == 0) begin
        idx = k / (T_MRD + 1);
        mr = 3'(order[idx % 7]);
        e.mrs = 1'b1;
        e.cs_n[idx / 7] = 1'b0;
        a = '0;
        case (mr)
          3'd6: a[12:10] = c[15:13];
          3'd4: begin a[12] = c[12]; a[11] = c[11]; end
          3'd2: a[5:3] = c[10:8];
          3'd1: a[4:3] = c[7:6];
          3'd0: begin
            a[6] = c[5]; a[5] = c[4]; a[4] = c[3]; a[2] = c[2];
            a[1:0] = c[1:0];
          end
          default: a = '0;
        endcase
        e.mode = {mr, a};
      end else begin
        e.des = 1'b1;
      end
    end else if (n > last_mrs() && n < zq_start()) begin
      e.des = 1'b1;
    end else if (n >= zq_start()) begin
      j = n - zq_start();
      if (j % (T_ZQ + 1) == 0) begin
        e.zq = 1'b1;
        e.cs_n[j / (T_ZQ + 1)] = 1'b0;
      end else begin
        e.des = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic drive_cfg(input logic [15:0] c);
    {tccd, wr_pre, rd_pre, cwl, al, cl, bl} = c;
  endtask

  // Compare every cycle n_from..n_to; optional noise scrambles cfg and fires ignored init_req pulses.
  task automatic run_cmp(input string tag, input logic [15:0] c, input int n_from,
                         input int n_to, input bit noise);
    obs_t exp_o;
    for (int n = n_from; n <= n_to; n++) begin
      @(posedge clk);
      #1;
      exp_o = model(n, c);
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, n, obs, exp_o);
      end
      if (noise) begin
        drive_cfg(16'($urandom));
        init_req = (n < done_at() - 1) && ($urandom_range(0, 15) == 0);
      end
    end
    init_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp_o;
    logic [15:0] c;
    c = 16'($urandom);
    drive_cfg(c);
    init_req = 1'b0;
    #2 rst = 1'b1;
    exp_o = model(0, c);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (obs !== exp_o) begin
        n_errors++;
        $display("FAIL reset_state: got %h expected %h", obs, exp_o);
      end
    end
  endtask

  task automatic test_power_up();
    logic [15:0] c;
    c = {3'b101, 1'b1, 1'b0, 3'b011, 2'b10, 4'b1010, 2'b01};
    drive_cfg(c);
    @(negedge clk);
    rst = 1'b0;
    run_cmp("powerup", c, 1, 24, 1'b1);
    n_checks++;
    if (mode_reg !== 20'hC1400) begin
      n_errors++;
      $display("FAIL mr6_tccd: got %h expected %h", mode_reg, 20'hC1400);
    end
    run_cmp("powerup", c, 25, 51, 1'b1);
    n_checks++;
    if (mode_reg !== 20'h40018) begin
      n_errors++;
      $display("FAIL mr2_cwl: got %h expected %h", mode_reg, 20'h40018);
    end
    run_cmp("powerup", c, 52, 69, 1'b1);
    n_checks++;
    if (mode_reg !== 20'h00051) begin
      n_errors++;
      $display("FAIL mr0_cl_bl: got %h expected %h", mode_reg, 20'h00051);
    end
    run_cmp("powerup", c, 70, 78, 1'b1);
    n_checks++;
    if ({mrs_rdy, cs_n, mode_reg} !== {1'b1, 2'b01, 20'h60000}) begin
      n_errors++;
      $display("FAIL rank1_mr3: got %h expected %h", {mrs_rdy, cs_n, mode_reg},
               {1'b1, 2'b01, 20'h60000});
    end
    run_cmp("powerup", c, 79, done_at() + 3, 1'b1);
  endtask

  task automatic test_reinit(input string tag);
    logic [15:0] c;
    obs_t exp_o;
    c = 16'($urandom);
    drive_cfg(c);
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    exp_o = model(0, c);
    n_checks++;
    if (obs !== exp_o) begin
      n_errors++;
      $display("FAIL %s_restart: got %h expected %h", tag, obs, exp_o);
    end
    run_cmp(tag, c, 1, done_at() + 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [15:0] c;
    logic [15:0] c2;
    obs_t exp_o;
    c = 16'($urandom);
    drive_cfg(c);
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    run_cmp("pre_reset", c, 1, 40, 1'b1);
    #2 rst = 1'b1;
    #1;
    exp_o = model(0, c);
    n_checks++;
    if (obs !== exp_o) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected %h", obs, exp_o);
    end
    repeat (2) @(posedge clk);
    c2 = 16'($urandom);
    drive_cfg(c2);
    @(negedge clk);
    rst = 1'b0;
    run_cmp("after_reset", c2, 1, done_at() + 3, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    init_req = 1'b0;
    drive_cfg(16'h0000);
    test_reset();
    test_power_up();
    test_reinit("reinit");
    test_reset_mid();
    test_reinit("back_to_back");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
